// File: rtl/mem_rd_pkg.sv
// Shared types and helpers for the burst reader and its read-latency pipe.
package mem_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

  // Width of a beat index into a buffer of max_beats words (at least 1 bit).
  function automatic int beat_idx_w(input int max_beats);
    return (max_beats > 1) ? $clog2(max_beats) : 1;
  endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// Delay line tracking issued reads: carries {valid, beat index} RD_LAT cycles
// so the returning word lands in the slot its address was issued for.
module rd_lat_pipe #(
  parameter int RD_LAT = 1,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             pending
);

  logic [RD_LAT-1:0]            vld_q, vld_d;
  logic [RD_LAT-1:0][IDX_W-1:0] idx_q, idx_d;

  // Shift every stage forward by one; stage 0 takes the newly issued read.
  always_comb begin
    vld_d    = '0;
    idx_d    = '0;
    vld_d[0] = in_valid;
    idx_d[0] = in_idx;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
  end

  // Stage registers; reset drops every read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q <= vld_d;
      idx_q <= idx_d;
    end
  end

  // Reads that will still return after the current cycle (excludes the last stage).
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      pending = pending | vld_q[i];
    end
  end

  assign out_valid = vld_q[RD_LAT-1];
  assign out_idx   = idx_q[RD_LAT-1];

endmodule

// File: rtl/mem_burst_reader.sv
// Burst reader: issues Len consecutive word reads from AddrIn, one per cycle,
// and assembles the returning words into DataBuff.
//
// Handshake: Start is a request sampled only while idle (Busy low); it is
// accepted on the first such clock edge, after which Busy stays high until
// and including the single done_vld cycle. done_vld is a one-cycle valid with
// no ready: DataBuff is complete on that cycle and holds until the next accept.
module mem_burst_reader
  import mem_rd_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MAX_BEATS = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic                              Start,
  input  logic [ADDR_W-1:0]                 AddrIn,
  input  logic [$clog2(MAX_BEATS+1)-1:0]    Len,
  input  logic [DATA_W-1:0]                 DataOut,
  output logic [ADDR_W-1:0]                 Addr,
  output logic                              RD,
  output logic [DATA_W*MAX_BEATS-1:0]       DataBuff,
  output logic                              Busy,
  output logic                              done_vld,
  output rd_state_e                         dbg_state
);

  localparam int                IDX_W   = beat_idx_w(MAX_BEATS);
  localparam int                LEN_W   = $clog2(MAX_BEATS + 1);
  localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(MAX_BEATS);

  rd_state_e                          state_q, state_d;
  logic [ADDR_W-1:0]                  addr_q, addr_d;
  logic [IDX_W-1:0]                   beat_q, beat_d;
  logic [IDX_W-1:0]                   last_q, last_d;
  logic [MAX_BEATS-1:0][DATA_W-1:0]   buff_q, buff_d;
  logic [LEN_W-1:0]                   len_eff;
  logic                               ret_valid;
  logic [IDX_W-1:0]                   ret_idx;
  logic                               rd_pending;

  rd_lat_pipe #(
    .RD_LAT (RD_LAT),
    .IDX_W  (IDX_W)
  ) u_pipe (
    .clk       (Clk),
    .rst       (Rst),
    .in_valid  (RD),
    .in_idx    (beat_q),
    .out_valid (ret_valid),
    .out_idx   (ret_idx),
    .pending   (rd_pending)
  );

  // Next-state, address/beat counters and buffer capture.
  always_comb begin
    len_eff = (Len > MAX_LEN) ? MAX_LEN : Len;
    state_d = state_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    last_d  = last_q;
    buff_d  = buff_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          buff_d  = '0;
          addr_d  = AddrIn;
          beat_d  = '0;
          last_d  = IDX_W'(len_eff - LEN_W'(1));
          state_d = (len_eff == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        addr_d = addr_q + ADDR_W'(1);
        beat_d = beat_q + IDX_W'(1);
        if (beat_q == last_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!rd_pending) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Returning words only exist while ISSUE/DRAIN, so this never races the clear.
    if (ret_valid) buff_d[ret_idx] = DataOut;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      last_q  <= '0;
      buff_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      buff_q  <= buff_d;
    end
  end

  assign RD        = (state_q == ST_ISSUE);
  assign Addr      = addr_q;
  assign Busy      = (state_q != ST_IDLE);
  assign done_vld  = (state_q == ST_DONE);
  assign DataBuff  = buff_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_burst_reader.sv
// Bench for mem_burst_reader: two instances (RD_LAT=1 and RD_LAT=3) driven
// by the same stimulus, each with its own memory model and expected queues.
module tb_mem_burst_reader;
  import mem_rd_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cyc = '0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  logic        start;
  logic [15:0] addr_in;
  logic [4:0]  len;

  logic [15:0]  dout0, dout1, addr0, addr1;
  logic         rd0, rd1, busy0, busy1, done0, done1;
  logic [255:0] buf0, buf1;
  rd_state_e    st0, st1;

  mem_burst_reader #(.DATA_W(16), .ADDR_W(16), .MAX_BEATS(16), .RD_LAT(1)) dut0 (
    .Clk(clk), .Rst(rst), .Start(start), .AddrIn(addr_in), .Len(len),
    .DataOut(dout0), .Addr(addr0), .RD(rd0), .DataBuff(buf0),
    .Busy(busy0), .done_vld(done0), .dbg_state(st0)
  );

  mem_burst_reader #(.DATA_W(16), .ADDR_W(16), .MAX_BEATS(16), .RD_LAT(3)) dut3 (
    .Clk(clk), .Rst(rst), .Start(start), .AddrIn(addr_in), .Len(len),
    .DataOut(dout1), .Addr(addr1), .RD(rd1), .DataBuff(buf1),
    .Busy(busy1), .done_vld(done1), .dbg_state(st1)
  );

  // ---------------- memory models: data = addr ^ 0xA5A5 ----------------
  logic [15:0] m0;
  logic [15:0] m1 [3];
  always @(posedge clk) begin
    m0    <= rd0 ? (addr0 ^ 16'hA5A5) : 16'hDEAD;
    m1[0] <= rd1 ? (addr1 ^ 16'hA5A5) : 16'hDEAD;
    m1[1] <= m1[0];
    m1[2] <= m1[1];
  end
  assign dout0 = m0;
  assign dout1 = m1[2];

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [47:0]  aq0[$], aq1[$];   // {cycle, address}
  logic [31:0]  dq0[$], dq1[$];   // done cycle
  logic [255:0] bq0[$], bq1[$];   // buffer at done

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s @cyc %0d: event missing or unexpected", name, cyc);
  endtask

  function automatic logic [255:0] exp_buf(input logic [15:0] a, input int n);
    logic [255:0] b;
    b = '0;
    for (int i = 0; i < n; i++) b[i*16 +: 16] = (a + 16'(i)) ^ 16'hA5A5;
    return b;
  endfunction

  task automatic push_addrs(input int k, input logic [31:0] t, input logic [15:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      if (k == 0) aq0.push_back({t + 32'(1 + i), a + 16'(i)});
      else        aq1.push_back({t + 32'(1 + i), a + 16'(i)});
    end
  endtask

  task automatic push_done(input int k, input logic [31:0] t, input logic [15:0] a, input int n);
    logic [31:0] dc;
    int lat;
    lat = (k == 0) ? 1 : 3;
    dc  = (n == 0) ? t + 32'd1 : t + 32'(1 + n + lat);
    if (k == 0) begin dq0.push_back(dc); bq0.push_back(exp_buf(a, n)); end
    else        begin dq1.push_back(dc); bq1.push_back(exp_buf(a, n)); end
  endtask

  // Monitor: pop and compare whenever an instance shows RD or done_vld.
  always @(negedge clk) begin
    if (rd0) begin
      if (aq0.size() == 0) fail_now("i0_unexpected_rd");
      else check("i0_cyc_addr", {cyc, addr0}, aq0.pop_front());
    end
    if (rd1) begin
      if (aq1.size() == 0) fail_now("i3_unexpected_rd");
      else check("i3_cyc_addr", {cyc, addr1}, aq1.pop_front());
    end
    if (done0) begin
      if (dq0.size() == 0) fail_now("i0_unexpected_done");
      else begin
        check("i0_done_cyc", cyc, dq0.pop_front());
        check("i0_buf", buf0, bq0.pop_front());
        check("i0_busy_at_done", busy0, 1);
      end
    end
    if (done1) begin
      if (dq1.size() == 0) fail_now("i3_unexpected_done");
      else begin
        check("i3_done_cyc", cyc, dq1.pop_front());
        check("i3_buf", buf1, bq1.pop_front());
        check("i3_busy_at_done", busy1, 1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_burst(input logic [15:0] a, input logic [4:0] l);
    int n;
    n = (l > 5'd16) ? 16 : int'(l);
    @(posedge clk); #1;
    start = 1'b1; addr_in = a; len = l;
    push_addrs(0, cyc, a, n); push_addrs(1, cyc, a, n);
    push_done(0, cyc, a, n);  push_done(1, cyc, a, n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int ok;
    ok = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!busy0 && !busy1 && dq0.size() == 0 && dq1.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) fail_now(name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] t;
    rst = 1'b1; start = 1'b0; addr_in = '0; len = '0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;

    // Reset state of both instances.
    check("rst_rd0", rd0, 0);      check("rst_rd3", rd1, 0);
    check("rst_addr0", addr0, 0);  check("rst_addr3", addr1, 0);
    check("rst_busy0", busy0, 0);  check("rst_busy3", busy1, 0);
    check("rst_done0", done0, 0);  check("rst_done3", done1, 0);
    check("rst_buf0", buf0, 0);    check("rst_buf3", buf1, 0);
    check("rst_state0", st0, ST_IDLE); check("rst_state3", st1, ST_IDLE);

    // Full 16-beat burst, Len=5 (upper slots stay zero), address wrap.
    start_burst(16'h0100, 5'd16); wait_idle("timeout_full");
    start_burst(16'h0040, 5'd5);  wait_idle("timeout_len5");
    start_burst(16'hFFFE, 5'd4);  wait_idle("timeout_wrap");
    // Len=0 after a non-empty burst must clear the buffer; Len=20 clamps to 16.
    start_burst(16'h5555, 5'd0);  wait_idle("timeout_len0");
    start_burst(16'h0800, 5'd20); wait_idle("timeout_clamp");

    // Reset during beat 7 of 16: only beats 0..7 are issued, no done.
    @(posedge clk); #1;
    start = 1'b1; addr_in = 16'h0A00; len = 5'd16; t = cyc;
    push_addrs(0, t, 16'h0A00, 8); push_addrs(1, t, 16'h0A00, 8);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_rd0", rd0, 0);     check("abort_rd3", rd1, 0);
    check("abort_busy0", busy0, 0); check("abort_busy3", busy1, 0);
    check("abort_done0", done0, 0); check("abort_done3", done1, 0);
    check("abort_buf0", buf0, 0);   check("abort_buf3", buf1, 0);
    repeat (6) @(posedge clk); #1;
    check("abort_late_buf0", buf0, 0); check("abort_late_buf3", buf1, 0);

    // Start held high: DONE cycle ignores it; the RD_LAT=1 instance
    // re-accepts once back in IDLE while the RD_LAT=3 one is still draining.
    @(posedge clk); #1;
    start = 1'b1; addr_in = 16'h0200; len = 5'd4; t = cyc;
    push_addrs(0, t, 16'h0200, 4); push_addrs(1, t, 16'h0200, 4);
    push_done(0, t, 16'h0200, 4);  push_done(1, t, 16'h0200, 4);
    push_addrs(0, t + 32'd7, 16'h0300, 2);
    push_done(0, t + 32'd7, 16'h0300, 2);
    @(posedge clk); #1;
    addr_in = 16'h0300; len = 5'd2;
    repeat (7) @(posedge clk); #1;
    start = 1'b0;
    wait_idle("timeout_held");

    repeat (5) @(negedge clk);
    check("left_aq0", aq0.size(), 0); check("left_aq3", aq1.size(), 0);
    check("left_dq0", dq0.size(), 0); check("left_dq3", dq1.size(), 0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_burst_reader.md
MEM_BURST_READER -- requirements
Module: mem_burst_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, memory word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 16, memory address width in bits.
REQ-003 SHALL have parameter MAX_BEATS, default 16, DataBuff depth in words (>=1).
REQ-004 SHALL have parameter RD_LAT, default 1, cycles from address issue to DataOut valid (>=1).
REQ-005 SHALL have port Clk  input  1  single clock; all logic on posedge; one clock, reset synchronous and active-high.
REQ-006 SHALL have port Rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port Start  input  1  burst request, sampled only in IDLE.
REQ-008 SHALL have port AddrIn  input  ADDR_W  burst base address, sampled with Start.
REQ-009 SHALL have port Len  input  $clog2(MAX_BEATS+1)  beat count, sampled with Start.
REQ-010 SHALL have port DataOut  input  DATA_W  memory read data.
REQ-011 SHALL have port Addr  output  ADDR_W  memory address.
REQ-012 SHALL have port RD  output  1  memory read strobe, one word per cycle while high.
REQ-013 SHALL have port DataBuff  output  DATA_W*MAX_BEATS  assembled burst; beat i at bits [i*DATA_W +: DATA_W].
REQ-014 SHALL have port Busy  output  1  high from the cycle after Start acceptance through the done_vld cycle.
REQ-015 SHALL have port done_vld  output  1  one-cycle pulse: DataBuff complete and stable.

Function
REQ-016 SHALL implement states IDLE, ISSUE, DRAIN, DONE; IDLE->ISSUE on Start (Len>=1), ISSUE->DRAIN after last address, DRAIN->DONE when no reads outstanding, DONE->IDLE unconditionally.
REQ-017 SHALL, on Start in IDLE with Len=0, go IDLE->DONE, issue no reads, clear DataBuff.
REQ-018 SHALL clamp Len>MAX_BEATS to MAX_BEATS.
REQ-019 SHALL, with Start accepted at cycle T, drive RD=1 and Addr=AddrIn+i in cycle T+1+i for i=0..Len-1, RD=0 otherwise.
REQ-020 SHALL compute Addr modulo 2^ADDR_W (wrap from all-ones to zero, no error).
REQ-021 SHALL capture DataOut into DataBuff slot i at the end of cycle T+1+i+RD_LAT.
REQ-022 SHALL clear all DataBuff slots to zero at Start acceptance; slots >=Len remain zero.
REQ-023 SHALL assert done_vld in cycle T+1+Len+RD_LAT (Len>=1), T+1 for Len=0; exactly one cycle.
REQ-024 SHALL ignore Start and AddrIn/Len whenever not in IDLE, including the DONE cycle.
REQ-025 SHALL hold DataBuff stable from done_vld until the next accepted Start.
REQ-026 SHALL be fully pipelined: no bubbles between beats for any RD_LAT.

Reset
REQ-027 SHALL, on Rst=1 at a clock edge, set state IDLE, RD=0, Addr=0, Busy=0, done_vld=0, DataBuff=0, clear outstanding-read tracking.
REQ-028 SHALL, on Rst mid-burst, abort without done_vld and discard data returning after reset.
REQ-029 SHALL give Rst priority over Start in the same cycle.

Structure
REQ-030 SHALL place state enum and beat-index width function in shared package mem_rd_pkg.
REQ-031 SHALL use one sub-module rd_lat_pipe: RD_LAT-deep delay line of {valid, beat index}, synchronous reset.

Verification
REQ-032 SHALL test defaults, AddrIn=0x0100, Len=16, memory returns addr^0xA5A5: Addr 0x0100..0x010F on 16 consecutive cycles, done_vld at T+18, every slot correct.
REQ-033 SHALL test RD_LAT=3, Len=5: RD high 5 cycles, done_vld at T+9, slots 5..15 zero.
REQ-034 SHALL test AddrIn=0xFFFE, Len=4: Addr 0xFFFE,0xFFFF,0x0000,0x0001.
REQ-035 SHALL test Len=0 -> no RD, done_vld at T+1, DataBuff=0; Len=20 -> 16 beats.
REQ-036 SHALL test Rst at beat 7 of 16: RD=0, Busy=0 next cycle, no done_vld, DataBuff=0.
REQ-037 SHALL test Start held high through burst and DONE: single burst only; a new burst is accepted only after IDLE.
